// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard beside decode: each destination gets a
// countdown of cycles until its result is consumable, and decode sources stall against it.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 4,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_AW-1:0]   src_a,
    input  logic                src_a_used,
    input  logic [REG_AW-1:0]   src_b,
    input  logic                src_b_used,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic [REG_AW-1:0]   issue_dst,
    input  logic [CNT_W-1:0]    issue_lat,
    input  logic                flush,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PERF_W-1:0]   stall_count
);

    localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] cnt      [NUM_REGS];
    logic [CNT_W-1:0] cnt_next [NUM_REGS];
    logic [CNT_W-1:0] lat_eff;
    logic [CNT_W-1:0] dec;
    logic             hit_a;
    logic             hit_b;
    logic             write_en;

    always_comb begin
        lat_eff = (issue_lat > MAX_LAT_C) ? MAX_LAT_C : issue_lat;
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    // Matching by loop means indices 0 and >= NUM_REGS can never hit or be written.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (src_a == REG_AW'(i) && busy_vec[i]) hit_a = 1'b1;
            if (src_b == REG_AW'(i) && busy_vec[i]) hit_b = 1'b1;
        end
        hit_a = hit_a & src_a_used;
        hit_b = hit_b & src_b_used;
    end

    assign stall      = issue_valid & (hit_a | hit_b);
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign write_en   = issue_fire & issue_we;

    // A re-write keeps the larger of the old remaining time and the new latency (WAW).
    always_comb begin
        dec         = '0;
        cnt_next[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            dec = (cnt[i] == '0) ? '0 : cnt[i] - CNT_W'(1);
            if (flush) begin
                cnt_next[i] = '0;
            end else if (write_en && issue_dst == REG_AW'(i)) begin
                cnt_next[i] = (dec > lat_eff) ? dec : lat_eff;
            end else begin
                cnt_next[i] = dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && stall_count != '1) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a reference model queues expected outputs
// per driven cycle; a second instance with a 4-bit perf counter checks saturation.
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int ML = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  src_a;
    logic        src_a_used;
    logic [4:0]  src_b;
    logic        src_b_used;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_dst;
    logic [2:0]  issue_lat;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic [15:0] stall_count;
    logic        stall_s;
    logic        issue_fire_s;
    logic [31:0] busy_vec_s;
    logic [3:0]  stall_count_s;

    typedef struct packed {
        logic        stall;
        logic        fire;
        logic [31:0] busy;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   mcnt[NR];
    int   mcount;
    int   checks;
    int   failures;
    logic last_stall;
    logic last_fire;
    int   n;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
        .issue_lat(issue_lat), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec), .stall_count(stall_count)
    );

    hazard_scoreboard #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
        .issue_lat(issue_lat), .flush(flush),
        .stall(stall_s), .issue_fire(issue_fire_s), .busy_vec(busy_vec_s),
        .stall_count(stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) mcnt[i] = 0;
        mcount = 0;
    endtask

    // Drives one decode cycle, queues the model's view, checks at negedge, then advances.
    task automatic applyStimulus(input logic v, input logic we, input int dst, input int lat,
                                 input int sa, input logic sau, input int sb, input logic sbu,
                                 input logic fl);
        exp_t e;
        exp_t got;
        logic ha;
        logic hb;
        int   d;
        int   le;
        issue_valid = v;   issue_we = we;     issue_dst = 5'(dst); issue_lat = 3'(lat);
        src_a = 5'(sa);    src_a_used = sau;  src_b = 5'(sb);      src_b_used = sbu;
        flush = fl;
        ha = sau && sa != 0 && mcnt[sa] != 0;
        hb = sbu && sb != 0 && mcnt[sb] != 0;
        e.stall = v && (ha || hb);
        e.fire  = v && !e.stall && !fl;
        e.busy  = '0;
        for (int i = 1; i < NR; i++) e.busy[i] = (mcnt[i] != 0);
        e.cnt16 = 16'(mcount);
        e.cnt4  = (mcount > 15) ? 4'd15 : 4'(mcount);
        exp_q.push_back(e);

        @(negedge clk);
        got = exp_q.pop_front();
        checkOutput("stall", 32'(stall), 32'(got.stall));
        checkOutput("issue_fire", 32'(issue_fire), 32'(got.fire));
        checkOutput("busy_vec", busy_vec, got.busy);
        checkOutput("stall_count", 32'(stall_count), 32'(got.cnt16));
        checkOutput("stall_count_sat", 32'(stall_count_s), 32'(got.cnt4));
        last_stall = stall;
        last_fire  = issue_fire;

        le = (lat > ML) ? ML : lat;
        for (int i = 1; i < NR; i++) begin
            d = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
            if (fl) mcnt[i] = 0;
            else if (e.fire && we && dst == i) mcnt[i] = (d > le) ? d : le;
            else mcnt[i] = d;
        end
        if (e.stall && mcount < 65535) mcount++;
        @(posedge clk);
        #1;
    endtask

    task automatic readUntilFire(input int r, output int stalls);
        logic done;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            applyStimulus(1, 0, 0, 0, r, 1, 0, 0, 0);
            if (last_stall) stalls++;
            if (last_fire) done = 1'b1;
        end
        if (!done) checkOutput("read_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        modelReset();
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_we = 1'b0; issue_dst = '0; issue_lat = '0;
        src_a = '0; src_a_used = 1'b0; src_b = '0; src_b_used = 1'b0; flush = 1'b0;
        #3;
        checkOutput("reset_stall", 32'(stall), 32'(0));
        checkOutput("reset_busy", busy_vec, 32'(0));
        checkOutput("reset_count", 32'(stall_count), 32'(0));
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1, 0, 0, 0, 7, 1, 0, 0, 0);
        checkOutput("first_fire", 32'(last_fire), 32'(1));

        applyStimulus(1, 1, 5, 2, 0, 0, 0, 0, 0);
        readUntilFire(5, n);
        checkOutput("r5_stall_cycles", 32'(n), 32'(2));
        checkOutput("r5_stall_count", 32'(stall_count), 32'(2));

        applyStimulus(1, 1, 0, 3, 0, 0, 0, 0, 0);
        readUntilFire(0, n);
        checkOutput("r0_stall_cycles", 32'(n), 32'(0));
        checkOutput("r0_busy", busy_vec, 32'(0));
        applyStimulus(1, 1, 9, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 9, 0, 9, 0, 0);
        checkOutput("r9_unused_src", 32'(last_stall), 32'(0));
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 1, 3, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 3, 1, 0, 0, 0, 0, 0);
        readUntilFire(3, n);
        checkOutput("waw_stall_cycles", 32'(n), 32'(2));
        applyStimulus(1, 1, 8, 7, 0, 0, 0, 0, 0);
        readUntilFire(8, n);
        checkOutput("clamp_stall_cycles", 32'(n), 32'(4));

        applyStimulus(1, 1, 4, 4, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 6, 3, 4, 1, 0, 0, 1);
        checkOutput("flush_cycle_stall", 32'(last_stall), 32'(1));
        checkOutput("flush_cycle_fire", 32'(last_fire), 32'(0));
        checkOutput("post_flush_busy", busy_vec, 32'(0));
        applyStimulus(1, 0, 0, 0, 4, 1, 6, 1, 0);
        checkOutput("post_flush_stall", 32'(last_stall), 32'(0));

        applyStimulus(1, 1, 2, 4, 0, 0, 0, 0, 0);
        issue_valid = 1'b1; issue_we = 1'b0; src_a = 5'd2; src_a_used = 1'b1;
        #1;
        checkOutput("pre_reset_stall", 32'(stall), 32'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_stall", 32'(stall), 32'(0));
        checkOutput("async_reset_busy", busy_vec, 32'(0));
        checkOutput("async_reset_count", 32'(stall_count), 32'(0));
        checkOutput("async_reset_count_sat", 32'(stall_count_s), 32'(0));
        rst_n = 1'b1;
        modelReset();

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 10, 4, 0, 0, 0, 0, 0);
            readUntilFire(10, n);
            checkOutput("sat_round_stalls", 32'(n), 32'(4));
        end
        checkOutput("long_stall_count", 32'(stall_count), 32'(20));
        checkOutput("saturated_count", 32'(stall_count_s), 32'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
